// File: rtl/ad9783_spi_responder_if.sv
// SPI bus between an AD9783-style controller (master) and the responder (slave).
// Signal names carry the responder's port-direction suffixes.
interface ad9783_spi_responder_if;
  logic spi_scs_in;
  logic spi_sck_in;
  logic spi_sdi_in;
  logic spi_sdo_out;
  logic spi_sdo_oe_out;

  modport master (
    output spi_scs_in, spi_sck_in, spi_sdi_in,
    input  spi_sdo_out, spi_sdo_oe_out
  );

  modport slave (
    input  spi_scs_in, spi_sck_in, spi_sdi_in,
    output spi_sdo_out, spi_sdo_oe_out
  );
endinterface

// File: rtl/ad9783_spi_responder.sv
// AD9783 16-bit SPI register protocol responder: 32 x 8 register file,
// oversampled SPI slave with write strobe, live SMP_DLY and abort counter.
module ad9783_spi_responder #(
  parameter logic [7:0] SMP_DLY_RST = 8'h00,
  parameter logic [7:0] VERSION     = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  ad9783_spi_responder_if.slave spi,
  output logic                 wr_stb_out,
  output logic [4:0]           wr_addr_out,
  output logic [7:0]           wr_data_out,
  output logic [7:0]           smp_dly_out,
  output logic [7:0]           abort_cnt_out
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [4:0] ADDR_SMP_DLY = 5'h05;
  localparam logic [4:0] ADDR_VERSION = 5'h1F;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    WDATA,
    RDATA,
    WAIT_CS
  } state_t;

  state_t              state_q, state_d;
  logic [STAGES-1:0]   scs_sync_q, scs_sync_d;
  logic [STAGES-1:0]   sck_sync_q, sck_sync_d;
  logic [STAGES-1:0]   sdi_sync_q, sdi_sync_d;
  logic                scs_prev_q, scs_prev_d;
  logic                sck_prev_q, sck_prev_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [4:0]          addr_q, addr_d;
  logic                n_ok_q, n_ok_d;
  logic [7:0]          rd_shift_q, rd_shift_d;
  logic                sdo_q, sdo_d;
  logic                sdo_oe_q, sdo_oe_d;
  logic                wr_stb_q, wr_stb_d;
  logic [4:0]          wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          abort_cnt_q, abort_cnt_d;
  logic [7:0]          regs_q [32];
  logic [7:0]          regs_d [32];

  logic       scs_s, sck_s, sdi_s;
  logic       scs_rise, scs_fall, sck_rise, sck_fall;
  logic [7:0] shift_in;

  assign scs_s    = scs_sync_q[STAGES-1];
  assign sck_s    = sck_sync_q[STAGES-1];
  assign sdi_s    = sdi_sync_q[STAGES-1];
  assign scs_rise =  scs_s & ~scs_prev_q;
  assign scs_fall = ~scs_s &  scs_prev_q;
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign shift_in = {shift_q[6:0], sdi_s};

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned, which would otherwise infer a latch.
    scs_sync_d  = {scs_sync_q[STAGES-2:0], spi.spi_scs_in};
    sck_sync_d  = {sck_sync_q[STAGES-2:0], spi.spi_sck_in};
    sdi_sync_d  = {sdi_sync_q[STAGES-2:0], spi.spi_sdi_in};
    scs_prev_d  = scs_s;
    sck_prev_d  = sck_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    n_ok_d      = n_ok_q;
    rd_shift_d  = rd_shift_q;
    sdo_d       = sdo_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    abort_cnt_d = abort_cnt_q;
    regs_d      = regs_q;

    case (state_q)
      IDLE: begin
        if (scs_fall) begin
          state_d   = INSTR;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end

      INSTR, WDATA, RDATA: begin
        // Chip-select release wins over a coincident final SCK edge.
        if (scs_rise) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
          if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          shift_d   = shift_in;
          if (state_q == INSTR && bit_cnt_q == 4'd7) begin
            addr_d  = shift_in[4:0];
            n_ok_d  = (shift_in[6:5] == 2'b00);
            shift_d = '0;
            if (shift_in[7]) begin
              state_d    = RDATA;
              rd_shift_d = (shift_in[6:5] == 2'b00) ? regs_q[shift_in[4:0]] : 8'h00;
            end else begin
              state_d = WDATA;
            end
          end else if (state_q == WDATA && bit_cnt_q == 4'd15) begin
            state_d = WAIT_CS;
            if (n_ok_q && addr_q != ADDR_VERSION) begin
              regs_d[addr_q] = shift_in;
              wr_stb_d       = 1'b1;
              wr_addr_d      = addr_q;
              wr_data_d      = shift_in;
            end
          end else if (state_q == RDATA && bit_cnt_q == 4'd15) begin
            state_d = WAIT_CS;
            sdo_d   = 1'b0;
          end
        end else if (sck_fall && state_q == RDATA) begin
          sdo_d      = rd_shift_q[7];
          rd_shift_d = {rd_shift_q[6:0], 1'b0};
        end
      end

      WAIT_CS: begin
        if (scs_rise) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    sdo_oe_d = (state_d == RDATA);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      scs_sync_q  <= '1;
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      scs_prev_q  <= 1'b1;
      sck_prev_q  <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      n_ok_q      <= 1'b0;
      rd_shift_q  <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      abort_cnt_q <= '0;
      // NOTE: the register file is reset like any other flop because its
      // reset contents (SMP_DLY, VERSION) are architecturally visible.
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == int'(ADDR_SMP_DLY)) ? SMP_DLY_RST :
                     (i == int'(ADDR_VERSION)) ? VERSION : 8'h00;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      scs_sync_q  <= scs_sync_d;
      sck_sync_q  <= sck_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      scs_prev_q  <= scs_prev_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      n_ok_q      <= n_ok_d;
      rd_shift_q  <= rd_shift_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      abort_cnt_q <= abort_cnt_d;
      regs_q      <= regs_d;
    end
  end

  assign spi.spi_sdo_out    = sdo_q;
  assign spi.spi_sdo_oe_out = sdo_oe_q;
  assign wr_stb_out         = wr_stb_q;
  assign wr_addr_out        = wr_addr_q;
  assign wr_data_out        = wr_data_q;
  assign smp_dly_out        = regs_q[ADDR_SMP_DLY];
  assign abort_cnt_out      = abort_cnt_q;

endmodule

// File: tb/tb_ad9783_spi_responder.sv
// Directed bench for ad9783_spi_responder: 10 MHz SPI master model driving
// write, read, abort, over-length and mid-frame-reset scenarios.
module tb_ad9783_spi_responder;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       wr_stb_out;
  logic [4:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic [7:0] smp_dly_out;
  logic [7:0] abort_cnt_out;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;

  ad9783_spi_responder_if spi ();

  ad9783_spi_responder #(
    .SMP_DLY_RST(8'h00),
    .VERSION    (8'h03),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .spi          (spi.slave),
    .wr_stb_out   (wr_stb_out),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out),
    .smp_dly_out  (smp_dly_out),
    .abort_cnt_out(abort_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  // Cycles with the strobe high; a clean single pulse adds exactly one.
  always @(negedge clk_in) if (wr_stb_out === 1'b1) stb_cnt <= stb_cnt + 1;

  task automatic spi_begin();
    spi.spi_scs_in = 1'b0;
    #100;
  endtask

  task automatic spi_bit(input logic b, output logic so, output logic oe);
    spi.spi_sdi_in = b;
    #50;
    so = spi.spi_sdo_out;
    oe = spi.spi_sdo_oe_out;
    spi.spi_sck_in = 1'b1;
    #50;
    spi.spi_sck_in = 1'b0;
  endtask

  task automatic spi_end();
    #100;
    spi.spi_scs_in = 1'b1;
    spi.spi_sdi_in = 1'b0;
    #200;
  endtask

  task automatic spi_xfer(input logic [23:0] bits, input int nbits,
                          output logic [15:0] sdo_cap, output logic [15:0] oe_cap);
    logic so, oe;
    sdo_cap = '0;
    oe_cap  = '0;
    spi_begin();
    for (int i = 0; i < nbits; i++) begin
      spi_bit(bits[23-i], so, oe);
      if (i < 16) begin
        sdo_cap = {sdo_cap[14:0], so};
        oe_cap  = {oe_cap[14:0], oe};
      end
    end
    spi_end();
  endtask

  task automatic spi_read(input logic [4:0] addr, input logic [1:0] n, output logic [7:0] data);
    logic [15:0] s, o;
    spi_xfer({1'b1, n, addr, 8'h00, 8'h00}, 16, s, o);
    data = s[7:0];
  endtask

  task automatic test_reset();
    #100;
    n_cmp++;
    if ({spi.spi_sdo_out, spi.spi_sdo_oe_out, wr_stb_out, wr_addr_out, wr_data_out, abort_cnt_out} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got sdo=%b oe=%b stb=%b addr=%h data=%h abort=%h want all 0",
               spi.spi_sdo_out, spi.spi_sdo_oe_out, wr_stb_out, wr_addr_out, wr_data_out, abort_cnt_out);
    end
    n_cmp++;
    if (smp_dly_out !== 8'h00) begin
      n_err++; $display("FAIL reset_smp_dly: got %h want 00", smp_dly_out);
    end
    rst_in = 1'b1;
    #100;
  endtask

  task automatic test_write();
    logic [15:0] s, o;
    int stb0 = stb_cnt;
    spi_xfer({16'h05A7, 8'h00}, 16, s, o);
    n_cmp++;
    if (stb_cnt - stb0 !== 1) begin n_err++; $display("FAIL write_stb: got %0d pulses want 1", stb_cnt - stb0); end
    n_cmp++;
    if (wr_addr_out !== 5'h05) begin n_err++; $display("FAIL write_addr: got %h want 05", wr_addr_out); end
    n_cmp++;
    if (wr_data_out !== 8'hA7) begin n_err++; $display("FAIL write_data: got %h want a7", wr_data_out); end
    n_cmp++;
    if (smp_dly_out !== 8'hA7) begin n_err++; $display("FAIL write_smp_dly: got %h want a7", smp_dly_out); end
  endtask

  task automatic test_read();
    logic [15:0] s, o;
    spi_xfer({16'h0255, 8'h00}, 16, s, o);
    spi_xfer({16'h8200, 8'h00}, 16, s, o);
    n_cmp++;
    if (s[7:0] !== 8'h55) begin n_err++; $display("FAIL read_data: got %h want 55", s[7:0]); end
    n_cmp++;
    if (o !== 16'h00FF) begin n_err++; $display("FAIL read_oe_window: got %h want 00ff", o); end
    n_cmp++;
    if (spi.spi_sdo_oe_out !== 1'b0) begin n_err++; $display("FAIL read_oe_idle: got %b want 0", spi.spi_sdo_oe_out); end
  endtask

  task automatic test_version();
    logic [15:0] s, o;
    logic [7:0]  d;
    int stb0;
    spi_read(5'h1F, 2'b00, d);
    n_cmp++;
    if (d !== 8'h03) begin n_err++; $display("FAIL version_read: got %h want 03", d); end
    stb0 = stb_cnt;
    spi_xfer({16'h1FFF, 8'h00}, 16, s, o);
    n_cmp++;
    if (stb_cnt - stb0 !== 0) begin n_err++; $display("FAIL version_wr_stb: got %0d pulses want 0", stb_cnt - stb0); end
    n_cmp++;
    if (wr_addr_out !== 5'h02) begin n_err++; $display("FAIL version_last_addr: got %h want 02", wr_addr_out); end
    spi_read(5'h1F, 2'b00, d);
    n_cmp++;
    if (d !== 8'h03) begin n_err++; $display("FAIL version_reread: got %h want 03", d); end
  endtask

  task automatic test_abort();
    logic [15:0] s, o;
    int stb0 = stb_cnt;
    spi_xfer({16'h0533, 8'h00}, 11, s, o);
    n_cmp++;
    if (smp_dly_out !== 8'hA7) begin n_err++; $display("FAIL abort_smp_dly: got %h want a7", smp_dly_out); end
    n_cmp++;
    if (stb_cnt - stb0 !== 0) begin n_err++; $display("FAIL abort_stb: got %0d pulses want 0", stb_cnt - stb0); end
    n_cmp++;
    if (abort_cnt_out !== 8'h01) begin n_err++; $display("FAIL abort_cnt_1: got %h want 01", abort_cnt_out); end
    for (int i = 0; i < 253; i++) begin spi_begin(); spi_end(); end
    n_cmp++;
    if (abort_cnt_out !== 8'hFE) begin n_err++; $display("FAIL abort_cnt_254: got %h want fe", abort_cnt_out); end
    for (int i = 0; i < 47; i++) begin spi_begin(); spi_end(); end
    n_cmp++;
    if (abort_cnt_out !== 8'hFF) begin n_err++; $display("FAIL abort_cnt_sat: got %h want ff", abort_cnt_out); end
  endtask

  task automatic test_extra_bits();
    logic [15:0] s, o;
    logic [7:0]  d;
    int stb0 = stb_cnt;
    spi_xfer({16'h0711, 4'hF, 4'h0}, 20, s, o);
    n_cmp++;
    if (stb_cnt - stb0 !== 1) begin n_err++; $display("FAIL extra_stb: got %0d pulses want 1", stb_cnt - stb0); end
    spi_read(5'h07, 2'b00, d);
    n_cmp++;
    if (d !== 8'h11) begin n_err++; $display("FAIL extra_reg07: got %h want 11", d); end
    stb0 = stb_cnt;
    spi_xfer({16'h2744, 8'h00}, 16, s, o);
    n_cmp++;
    if (stb_cnt - stb0 !== 0) begin n_err++; $display("FAIL bad_n_stb: got %0d pulses want 0", stb_cnt - stb0); end
    spi_read(5'h07, 2'b00, d);
    n_cmp++;
    if (d !== 8'h11) begin n_err++; $display("FAIL bad_n_reg07: got %h want 11", d); end
    spi_read(5'h07, 2'b01, d);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL bad_n_read: got %h want 00", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] s, o;
    logic [15:0] word = 16'h05C3;
    logic        so, oe;
    int          stb0;
    spi_begin();
    for (int i = 0; i < 12; i++) spi_bit(word[15-i], so, oe);
    rst_in = 1'b0;
    #50;
    n_cmp++;
    if (smp_dly_out !== 8'h00) begin n_err++; $display("FAIL midrst_smp_dly: got %h want 00", smp_dly_out); end
    n_cmp++;
    if (abort_cnt_out !== 8'h00) begin n_err++; $display("FAIL midrst_abort: got %h want 00", abort_cnt_out); end
    spi.spi_scs_in = 1'b1;
    spi.spi_sdi_in = 1'b0;
    #100;
    rst_in = 1'b1;
    #100;
    stb0 = stb_cnt;
    spi_xfer({16'h055A, 8'h00}, 16, s, o);
    n_cmp++;
    if (smp_dly_out !== 8'h5A) begin n_err++; $display("FAIL post_rst_smp_dly: got %h want 5a", smp_dly_out); end
    n_cmp++;
    if (stb_cnt - stb0 !== 1) begin n_err++; $display("FAIL post_rst_stb: got %0d pulses want 1", stb_cnt - stb0); end
    n_cmp++;
    if (abort_cnt_out !== 8'h00) begin n_err++; $display("FAIL post_rst_abort: got %h want 00", abort_cnt_out); end
  endtask

  initial begin
    spi.spi_scs_in = 1'b1;
    spi.spi_sck_in = 1'b0;
    spi.spi_sdi_in = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_version();
    test_abort();
    test_extra_bits();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
